// File: rtl/remote_cmd_decoder_pkg.sv
// Shared types and key codes for the IR remote command decoder.
// Speed modes, FSM states and the NEC key bytes recognised by the decoder.
package remote_pkg;

    typedef enum logic [1:0] {
        SPEED_NORMAL = 2'd0,
        SPEED_SLOW   = 2'd1,
        SPEED_FAST   = 2'd2
    } speed_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    typedef struct packed {
        logic power;
        logic playpause;
        logic restart;
        logic next_song;
        logic prev_song;
        logic reject;
    } pulses_t;

    localparam logic [7:0] KEY_POWER     = 8'h12;
    localparam logic [7:0] KEY_PLAYPAUSE = 8'h16;
    localparam logic [7:0] KEY_RETURN    = 8'h17;
    localparam logic [7:0] KEY_A         = 8'h0F;
    localparam logic [7:0] KEY_B         = 8'h13;
    localparam logic [7:0] KEY_C         = 8'h10;
    localparam logic [7:0] KEY_NEXT      = 8'h18;
    localparam logic [7:0] KEY_PREV      = 8'h14;

    // NEC frames carry the key byte followed by its bitwise complement.
    function automatic logic complement_ok(input logic [31:0] frame);
        return frame[31:24] == ~frame[23:16];
    endfunction

endpackage

// File: rtl/remote_cmd_decoder_holdoff.sv
// Down-counter used to suppress auto-repeat of the last accepted key.
// Loading zero leaves the timer expired, which disables the hold-off.
module holdoff_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             CLOCK,
    input  logic             iRST_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge iRST_n) begin
        if (!iRST_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/remote_cmd_decoder.sv
// Validates NEC frames from the IR receiver and turns key bytes into one-cycle
// command pulses plus persistent song index and playback speed.
module remote_cmd_decoder
    import remote_pkg::*;
#(
    parameter int unsigned NUM_SONGS      = 2,
    parameter int unsigned SONG_W         = 4,
    parameter int unsigned HOLDOFF_CYCLES = 12500000,
    parameter bit          CHECK_CUSTOM   = 1'b1,
    parameter logic [15:0] CUSTOM_CODE    = 16'h6B86
) (
    input  logic              CLOCK,
    input  logic              iRST_n,
    input  logic              data_ready,
    input  logic [31:0]       keycode,
    output logic              reset_pulse,
    output logic              playpause_pulse,
    output logic              restart_pulse,
    output logic              next_pulse,
    output logic              prev_pulse,
    output logic              reject_pulse,
    output logic [SONG_W-1:0] song_idx,
    output logic [1:0]        speed_mode,
    output logic              busy
);

    localparam int unsigned HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [HO_W-1:0]   HO_LOAD   = HO_W'(HOLDOFF_CYCLES);
    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

    state_t            state_q, state_d;
    pulses_t           pulses_q, pulses_d;
    logic [SONG_W-1:0] song_q, song_d;
    speed_t            speed_q, speed_d;
    logic [7:0]        last_key_q, last_key_d;
    logic              busy_q, busy_d;

    logic              holdoff_load;
    logic              holdoff_expired;
    logic              holdoff_active;
    logic              frame_valid;
    logic              custom_ok;
    logic [7:0]        key;
    logic              accept;

    holdoff_timer #(
        .CNT_W (HO_W)
    ) u_holdoff (
        .CLOCK   (CLOCK),
        .iRST_n  (iRST_n),
        .load    (holdoff_load),
        .value   (HO_LOAD),
        .expired (holdoff_expired)
    );

    assign holdoff_active = !holdoff_expired;
    assign key            = keycode[23:16];
    assign custom_ok      = !CHECK_CUSTOM || (keycode[15:0] == CUSTOM_CODE);
    assign frame_valid    = complement_ok(keycode) && custom_ok;

    always_comb begin
        state_d      = state_q;
        pulses_d     = '0;
        song_d       = song_q;
        speed_d      = speed_q;
        last_key_d   = last_key_q;
        holdoff_load = 1'b0;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_ready) begin
                    state_d = ST_SETTLE;
                end
            end
            // keycode is still changing on the strobe cycle; wait one clock.
            ST_SETTLE: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (!frame_valid) begin
                    pulses_d.reject = 1'b1;
                end else if (!(key == last_key_q && holdoff_active)) begin
                    accept = 1'b1;
                    case (key)
                        KEY_POWER: begin
                            pulses_d.power = 1'b1;
                            song_d         = '0;
                            speed_d        = SPEED_NORMAL;
                        end
                        KEY_PLAYPAUSE: pulses_d.playpause = 1'b1;
                        KEY_RETURN:    pulses_d.restart   = 1'b1;
                        KEY_C:         speed_d = SPEED_FAST;
                        KEY_A:         speed_d = SPEED_SLOW;
                        KEY_B:         speed_d = SPEED_NORMAL;
                        KEY_NEXT: begin
                            pulses_d.next_song = 1'b1;
                            song_d = (song_q == LAST_SONG) ? '0 : song_q + 1'b1;
                        end
                        KEY_PREV: begin
                            pulses_d.prev_song = 1'b1;
                            song_d = (song_q == '0) ? LAST_SONG : song_q - 1'b1;
                        end
                        default: begin
                            pulses_d.reject = 1'b1;
                            accept          = 1'b0;
                        end
                    endcase
                    if (accept) begin
                        last_key_d   = key;
                        holdoff_load = 1'b1;
                    end
                end
                // A repeat inside the hold-off window falls through with no effect.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= ST_IDLE;
            pulses_q   <= '0;
            song_q     <= '0;
            speed_q    <= SPEED_NORMAL;
            last_key_q <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pulses_q   <= pulses_d;
            song_q     <= song_d;
            speed_q    <= speed_d;
            last_key_q <= last_key_d;
            busy_q     <= busy_d;
        end
    end

    assign reset_pulse     = pulses_q.power;
    assign playpause_pulse = pulses_q.playpause;
    assign restart_pulse   = pulses_q.restart;
    assign next_pulse      = pulses_q.next_song;
    assign prev_pulse      = pulses_q.prev_song;
    assign reject_pulse    = pulses_q.reject;
    assign song_idx        = song_q;
    assign speed_mode      = speed_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_remote_cmd_decoder.sv
// Scoreboard bench: dut_a (3 songs, hold-off 100, custom check) and
// dut_b (1 song, no hold-off, no custom check).
`timescale 1ns/1ps
module tb_remote_cmd_decoder;

    localparam logic [31:0] F_PLAY  = 32'hE916_6B86;
    localparam logic [31:0] F_NEXT  = 32'hE718_6B86;
    localparam logic [31:0] F_PREV  = 32'hEB14_6B86;
    localparam logic [31:0] F_A     = 32'hF00F_6B86;
    localparam logic [31:0] F_B     = 32'hEC13_6B86;
    localparam logic [31:0] F_C     = 32'hEF10_6B86;
    localparam logic [31:0] F_POWER = 32'hED12_6B86;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_n;
    logic        dr_a, dr_b;
    logic [31:0] keycode;
    logic        rst_a, pp_a, rs_a, nx_a, pv_a, rj_a, busy_a;
    logic        rst_b, pp_b, rs_b, nx_b, pv_b, rj_b, busy_b;
    logic [3:0]  song_a, song_b;
    logic [1:0]  speed_a, speed_b;
    logic [11:0] vec_a, vec_b;

    assign vec_a = {rst_a, pp_a, rs_a, nx_a, pv_a, rj_a, song_a, speed_a};
    assign vec_b = {rst_b, pp_b, rs_b, nx_b, pv_b, rj_b, song_b, speed_b};

    remote_cmd_decoder #(
        .NUM_SONGS(3), .SONG_W(4), .HOLDOFF_CYCLES(100), .CHECK_CUSTOM(1'b1), .CUSTOM_CODE(16'h6B86)
    ) dut_a (
        .CLOCK(clk), .iRST_n(rst_n), .data_ready(dr_a), .keycode(keycode),
        .reset_pulse(rst_a), .playpause_pulse(pp_a), .restart_pulse(rs_a),
        .next_pulse(nx_a), .prev_pulse(pv_a), .reject_pulse(rj_a),
        .song_idx(song_a), .speed_mode(speed_a), .busy(busy_a)
    );

    remote_cmd_decoder #(
        .NUM_SONGS(1), .SONG_W(4), .HOLDOFF_CYCLES(0), .CHECK_CUSTOM(1'b0), .CUSTOM_CODE(16'h6B86)
    ) dut_b (
        .CLOCK(clk), .iRST_n(rst_n), .data_ready(dr_b), .keycode(keycode),
        .reset_pulse(rst_b), .playpause_pulse(pp_b), .restart_pulse(rs_b),
        .next_pulse(nx_b), .prev_pulse(pv_b), .reject_pulse(rj_b),
        .song_idx(song_b), .speed_mode(speed_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] exp_a[$], obs_a[$], exp_b[$], obs_b[$];
    logic busy_a_prev = 1'b0, busy_b_prev = 1'b0;

    // A transaction completes when busy falls; snapshot all outputs then.
    always @(negedge clk) begin
        if (busy_a_prev && !busy_a) obs_a.push_back(vec_a);
        if (busy_b_prev && !busy_b) obs_b.push_back(vec_b);
        busy_a_prev <= busy_a;
        busy_b_prev <= busy_b;
    end

    // Reference model for dut_a.
    int          m_song, m_speed, m_acc;
    logic [7:0]  m_last;

    function automatic void model_reset();
        m_song = 0; m_speed = 0; m_acc = -1000; m_last = 8'h00;
    endfunction

    function automatic logic [11:0] predict(input logic [31:0] kc, input int dec);
        logic [5:0] p;
        logic [7:0] k;
        logic       mapped;
        p = 6'd0; k = kc[23:16]; mapped = 1'b1;
        if (kc[31:24] !== ~kc[23:16] || kc[15:0] !== 16'h6B86) begin
            p = 6'b000001;
        end else if (k == m_last && (dec - m_acc) <= 100) begin
            p = 6'd0;
        end else begin
            case (k)
                8'h12: begin p = 6'b100000; m_song = 0; m_speed = 0; end
                8'h16: p = 6'b010000;
                8'h17: p = 6'b001000;
                8'h10: m_speed = 2;
                8'h0F: m_speed = 1;
                8'h13: m_speed = 0;
                8'h18: begin p = 6'b000100; m_song = (m_song + 1) % 3; end
                8'h14: begin p = 6'b000010; m_song = (m_song + 2) % 3; end
                default: begin p = 6'b000001; mapped = 1'b0; end
            endcase
            if (mapped) begin m_last = k; m_acc = dec; end
        end
        return {p, 4'(m_song), 2'(m_speed)};
    endfunction

    // Called at a negedge; strobe is sampled on the next posedge (edge N).
    task automatic send_a(input logic [31:0] kc);
        keycode = kc; dr_a = 1'b1;
        exp_a.push_back(predict(kc, cyc + 3));
        @(negedge clk); dr_a = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_b(input logic [31:0] kc, input logic [11:0] want);
        keycode = kc; dr_b = 1'b1;
        exp_b.push_back(want);
        @(negedge clk); dr_b = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_to(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (vec_a !== 12'h000 || busy_a !== 1'b0) begin
            errors++; $display("FAIL reset_a got=%h/%b want=000/0", vec_a, busy_a);
        end
        checks++;
        if (vec_b !== 12'h000 || busy_b !== 1'b0) begin
            errors++; $display("FAIL reset_b got=%h/%b want=000/0", vec_b, busy_b);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (vec_a !== 12'h000 || busy_a !== 1'b0) begin
            errors++; $display("FAIL post_reset got=%h/%b want=000/0", vec_a, busy_a);
        end
        $display("tx reset vec_a=%h vec_b=%h", vec_a, vec_b);
    endtask

    task automatic test_latency();
        logic [11:0] got, want;
        keycode = F_PLAY; dr_a = 1'b1;
        exp_a.push_back(predict(F_PLAY, cyc + 3));
        @(negedge clk); dr_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || pp_a !== 1'b0) begin
            errors++; $display("FAIL lat_n busy/pp got=%b%b want=10", busy_a, pp_a);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || pp_a !== 1'b0) begin
            errors++; $display("FAIL lat_n1 busy/pp got=%b%b want=10", busy_a, pp_a);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || pp_a !== 1'b1) begin
            errors++; $display("FAIL lat_n2 busy/pp got=%b%b want=01", busy_a, pp_a);
        end
        @(negedge clk);
        checks++;
        if (pp_a !== 1'b0) begin
            errors++; $display("FAIL lat_n3 pp got=%b want=0", pp_a);
        end
        want = exp_a.pop_front();
        checks++;
        if (obs_a.size() == 0) begin
            errors++; $display("FAIL lat_sb no output want=%h", want);
        end else begin
            got = obs_a.pop_front();
            if (got !== want) begin errors++; $display("FAIL lat_sb got=%h want=%h", got, want); end
        end
        $display("tx latency kc=%h want=%h", F_PLAY, want);
    endtask

    task automatic run_table_a(input string name, input logic [31:0] kcs[], input int offs[]);
        int t0;
        logic [11:0] got, want;
        t0 = cyc + 1;
        for (int i = 0; i < kcs.size(); i++) begin
            wait_to(t0 + offs[i]);
            send_a(kcs[i]);
            want = exp_a.pop_front();
            checks++;
            if (obs_a.size() == 0) begin
                errors++; $display("FAIL %s[%0d] no output want=%h", name, i, want);
            end else begin
                got = obs_a.pop_front();
                if (got !== want) begin
                    errors++; $display("FAIL %s[%0d] kc=%h got=%h want=%h", name, i, kcs[i], got, want);
                end
                $display("tx %s[%0d] kc=%h got=%h want=%h", name, i, kcs[i], got, want);
            end
        end
    endtask

    task automatic test_song_wrap();
        logic [31:0] kcs[] = '{F_NEXT, F_NEXT, F_NEXT, F_NEXT, F_PREV, F_PREV};
        int offs[] = '{0, 120, 240, 360, 480, 600};
        run_table_a("song", kcs, offs);
        checks++;
        if (song_a !== 4'd2) begin errors++; $display("FAIL song_final got=%0d want=2", song_a); end
    endtask

    task automatic test_reject();
        logic [31:0] kcs[] = '{32'h1216_6B86, 32'hE916_1234, 32'hAA55_6B86};
        int offs[] = '{0, 10, 20};
        run_table_a("reject", kcs, offs);
    endtask

    task automatic test_holdoff();
        logic [31:0] kcs[] = '{F_PLAY, F_PLAY, F_C, F_PLAY, F_PLAY, F_PLAY, F_PLAY};
        int offs[] = '{0, 50, 60, 170, 270, 274, 375};
        run_table_a("holdoff", kcs, offs);
    endtask

    task automatic test_speed_power();
        logic [31:0] kcs[] = '{F_A, F_C, F_B, F_C, F_POWER};
        int offs[] = '{0, 5, 10, 15, 20};
        run_table_a("speed", kcs, offs);
        checks++;
        if (song_a !== 4'd0 || speed_a !== 2'd0) begin
            errors++; $display("FAIL power_state got=%0d/%0d want=0/0", song_a, speed_a);
        end
    endtask

    task automatic test_ignore_busy();
        logic [11:0] got, want;
        keycode = F_NEXT; dr_a = 1'b1;
        exp_a.push_back(predict(F_NEXT, cyc + 3));
        @(negedge clk); dr_a = 1'b1;
        @(negedge clk); dr_a = 1'b0;
        repeat (8) @(negedge clk);
        want = exp_a.pop_front();
        checks++;
        if (obs_a.size() == 0) begin
            errors++; $display("FAIL ignore no output want=%h", want);
        end else begin
            got = obs_a.pop_front();
            if (got !== want) begin errors++; $display("FAIL ignore got=%h want=%h", got, want); end
        end
        checks++;
        if (obs_a.size() != 0) begin
            errors++; $display("FAIL ignore_extra got=%0d extra transactions want=0", obs_a.size());
            obs_a.delete();
        end
        $display("tx ignore kc=%h want=%h", F_NEXT, want);
    endtask

    task automatic test_dut_b();
        logic [31:0] kcs[]  = '{32'hE916_1234, F_NEXT, F_NEXT, 32'hEB14_1234, 32'h1216_6B86, F_A};
        logic [11:0] wants[] = '{12'h400, 12'h100, 12'h100, 12'h080, 12'h040, 12'h001};
        logic [11:0] got, want;
        for (int i = 0; i < kcs.size(); i++) begin
            send_b(kcs[i], wants[i]);
            want = exp_b.pop_front();
            checks++;
            if (obs_b.size() == 0) begin
                errors++; $display("FAIL dutb[%0d] no output want=%h", i, want);
            end else begin
                got = obs_b.pop_front();
                if (got !== want) begin
                    errors++; $display("FAIL dutb[%0d] kc=%h got=%h want=%h", i, kcs[i], got, want);
                end
                $display("tx dutb[%0d] kc=%h got=%h want=%h", i, kcs[i], got, want);
            end
        end
    endtask

    task automatic test_reset_mid_decode();
        logic [11:0] got, want;
        send_a(F_C);
        want = exp_a.pop_front();
        checks++;
        if (obs_a.size() == 0) begin
            errors++; $display("FAIL pre_rst no output want=%h", want);
        end else begin
            got = obs_a.pop_front();
            if (got !== want) begin errors++; $display("FAIL pre_rst got=%h want=%h", got, want); end
        end
        keycode = F_PLAY; dr_a = 1'b1;
        @(negedge clk); dr_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (vec_a !== 12'h000 || busy_a !== 1'b0) begin
            errors++; $display("FAIL rst_mid got=%h/%b want=000/0", vec_a, busy_a);
        end
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (vec_a !== 12'h000 || busy_a !== 1'b0) begin
                errors++; $display("FAIL rst_after[%0d] got=%h/%b want=000/0", i, vec_a, busy_a);
            end
        end
        obs_a.delete();
        obs_b.delete();
        $display("tx reset_mid_decode vec_a=%h", vec_a);
    endtask

    task automatic test_recover();
        logic [31:0] kcs[] = '{F_PLAY, F_NEXT};
        int offs[] = '{0, 5};
        run_table_a("recover", kcs, offs);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dr_a = 1'b0; dr_b = 1'b0; keycode = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_latency();
        test_song_wrap();
        test_reject();
        test_holdoff();
        test_speed_power();
        test_ignore_busy();
        test_dut_b();
        test_reset_mid_decode();
        test_recover();
        checks++;
        if (exp_a.size() != 0 || obs_a.size() != 0 || exp_b.size() != 0 || obs_b.size() != 0) begin
            errors++;
            $display("FAIL queues_drained got=%0d/%0d/%0d/%0d want=0/0/0/0",
                     exp_a.size(), obs_a.size(), exp_b.size(), obs_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
